// File: rtl/bus_breakout_pipe.sv
// Two-bus breakout with run-time operation select, queued behind a
// valid/ready FIFO, plus a saturating accepted-beat counter.
module bus_breakout_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 6,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_q,
    output logic             out_ovf,
    output logic [CNT_W-1:0] beat_count
);

    localparam int H  = OUT_W / 2;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]    PTR_LAST = PW'(DEPTH - 1);
    localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] MODE_CONCAT = 2'd0;
    localparam logic [1:0] MODE_SWAP   = 2'd1;
    localparam logic [1:0] MODE_SUM    = 2'd2;

    logic [OUT_W-1:0] mem_q   [DEPTH];
    logic [OUT_W-1:0] mem_d   [DEPTH];
    logic             mem_ovf_q [DEPTH];
    logic             mem_ovf_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [OUT_W-1:0] hold_q_q, hold_q_d;
    logic             hold_ovf_q, hold_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [OUT_W:0]   sum_w;
    logic [OUT_W-1:0] res_q;
    logic             res_ovf;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        sum_w   = (OUT_W+1)'(in_a) + (OUT_W+1)'(in_b);
        res_q   = '0;
        res_ovf = 1'b0;
        case (in_mode)
            MODE_CONCAT: res_q = {in_a[IN_W-1 -: H], in_b[H-1:0]};
            MODE_SWAP:   res_q = {in_b[IN_W-1 -: H], in_a[H-1:0]};
            MODE_SUM: begin
                res_q   = sum_w[OUT_W-1:0];
                res_ovf = sum_w[OUT_W];
            end
            default:     res_q = OUT_W'(in_a ^ in_b);
        endcase
    end

    // Readiness depends only on stored occupancy and reset, never on out_ready.
    assign in_ready   = !rst && (occ_q < OCC_FULL);
    assign out_valid  = (occ_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_q      = out_valid ? mem_q[rd_ptr_q] : hold_q_q;
    assign out_ovf    = out_valid ? mem_ovf_q[rd_ptr_q] : hold_ovf_q;
    assign beat_count = cnt_q;

    always_comb begin
        mem_d      = mem_q;
        mem_ovf_d  = mem_ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        hold_q_d   = hold_q_q;
        hold_ovf_d = hold_ovf_q;
        cnt_d      = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q]     = res_q;
            mem_ovf_d[wr_ptr_q] = res_ovf;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Remember the departing head so an empty FIFO keeps showing it.
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            hold_q_d   = mem_q[rd_ptr_q];
            hold_ovf_d = mem_ovf_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]     <= '0;
                mem_ovf_q[i] <= 1'b0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            hold_q_q   <= '0;
            hold_ovf_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            mem_ovf_q  <= mem_ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            hold_q_q   <= hold_q_d;
            hold_ovf_q <= hold_ovf_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_breakout_pipe.sv
// Scoreboard bench: driver pushes expected results, monitor pops on output
// handshakes; a second narrow instance covers SUM wrap and counter saturation.
module tb_bus_breakout_pipe;

    localparam int IN_W  = 4;
    localparam int OUT_W = 6;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int H     = OUT_W / 2;

    typedef struct {
        int q;
        int ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_a = '0;
    logic [IN_W-1:0]  in_b = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_q;
    logic             out_ovf;
    logic [CNT_W-1:0] beat_count;

    logic       v4 = 1'b0;
    logic       rdy4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic [1:0] m4 = 2'd2;
    logic       ov4;
    logic       ordy4 = 1'b0;
    logic [3:0] q4;
    logic       f4;
    logic [2:0] cnt4;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc  = 0;
    exp_t sb[$];
    exp_t last;

    always #5 clk = ~clk;

    bus_breakout_pipe #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_ovf(out_ovf),
        .beat_count(beat_count)
    );

    bus_breakout_pipe #(
        .IN_W(4), .OUT_W(4), .DEPTH(1), .CNT_W(3)
    ) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(rdy4),
        .in_a(a4), .in_b(b4), .in_mode(m4),
        .out_valid(ov4), .out_ready(ordy4),
        .out_q(q4), .out_ovf(f4),
        .beat_count(cnt4)
    );

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    function automatic exp_t model(input int a, input int b, input int m);
        exp_t e;
        int   s;
        e.ovf = 0;
        case (m)
            0: e.q = (a / (2**(IN_W-H))) * (2**H) + b % (2**H);
            1: e.q = (b / (2**(IN_W-H))) * (2**H) + a % (2**H);
            2: begin
                s     = a + b;
                e.q   = s % (2**OUT_W);
                e.ovf = (s >= 2**OUT_W) ? 1 : 0;
            end
            default: e.q = a ^ b;
        endcase
        return e;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic cycle(input bit r, input bit v, input int a, input int b,
                         input int m, input bit ordy);
        int occ;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_a      = a[IN_W-1:0];
        in_b      = b[IN_W-1:0];
        in_mode   = m[1:0];
        out_ready = ordy;
        #1;
        occ = sb.size();
        check("in_ready", int'(in_ready), (!r && occ < DEPTH) ? 1 : 0);
        check("out_valid", int'(out_valid), (occ != 0) ? 1 : 0);
        check("beat_count", int'(beat_count), sat(n_acc, 2**CNT_W - 1));
        if (occ == 0) begin
            check("idle_q", int'(out_q), last.q);
            check("idle_ovf", int'(out_ovf), last.ovf);
        end
        if (r) begin
            sb.delete();
            n_acc    = 0;
            last.q   = 0;
            last.ovf = 0;
        end else if (v && in_ready) begin
            sb.push_back(model(a, b, m));
            n_acc++;
        end
    endtask

    // Monitor: head must match the oldest expected entry every valid cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", int'(out_q), -1);
                end else begin
                    check("head_q", int'(out_q), sb[0].q);
                    check("head_ovf", int'(out_ovf), sb[0].ovf);
                    if (out_ready) begin
                        e    = sb.pop_front();
                        last = e;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        int n4;
        last.q   = 0;
        last.ovf = 0;
        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // directed: concat, swap, xor, sum without overflow at OUT_W=6
        cycle(0, 1, 11, 6, 0, 1);
        cycle(0, 1, 11, 6, 1, 1);
        cycle(0, 1, 11, 6, 3, 1);
        cycle(0, 1, 15, 2, 2, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        check("concat_const", model(11, 6, 0).q, 46);
        // backpressure
        for (int k = 0; k < 4; k++) cycle(0, 1, k, k, 2, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 1);
        // simultaneous push/pop at occupancy 1
        cycle(0, 1, 3, 5, 2, 0);
        for (int k = 0; k < 8; k++) cycle(0, 1, k, 15 - k, k % 4, 1);
        repeat (3) cycle(0, 0, 0, 0, 0, 1);
        // reset with two entries queued
        cycle(0, 1, 9, 9, 0, 0);
        cycle(0, 1, 7, 1, 1, 0);
        cycle(1, 1, 1, 1, 2, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(i == 200, ($urandom % 4) != 0, $urandom % 16,
                  $urandom % 16, $urandom % 4, ($urandom % 3) != 0);
        end
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            cycle(0, 0, 0, 0, 0, 1);
            guard++;
        end
        check("drain", sb.size(), 0);
        // narrow instance: 15+2 wraps at 4 bits, counter saturates at 7
        n4 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            v4    = 1'b1;
            a4    = 4'hF;
            b4    = 4'h2;
            m4    = 2'd2;
            ordy4 = 1'b1;
            #1;
            check("cnt4", int'(cnt4), sat(n4, 7));
            check("rdy4", int'(rdy4), ov4 ? 0 : 1);
            if (ov4) begin
                check("sum4_q", int'(q4), (15 + 2) % 16);
                check("sum4_ovf", int'(f4), (15 + 2) / 16);
            end
            if (rdy4) n4++;
        end
        @(negedge clk);
        v4 = 1'b0;
        #1;
        check("cnt4_final", int'(cnt4), sat(n4, 7));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_breakout_pipe.md
Name: bus_breakout_pipe

Overview:
- Parametrised, pipelined successor to the combinational bus breakout.
- Takes two input buses A and B per beat and builds an OUT_W-bit result in one of four run-time modes: slice-concatenate, swapped concatenate, sum, or XOR.
- Results are queued in a DEPTH-entry FIFO behind valid/ready handshakes on both sides.
- Sits between a producer and consumer that both use valid/ready streaming, and keeps a saturating beat counter for bring-up.

Parameters:
- IN_W, 4: width of each input bus.
- OUT_W, 6: result width. Must be even, with OUT_W/2 <= IN_W and OUT_W >= IN_W.
- DEPTH, 2: output FIFO entries. Must be >= 1.
- CNT_W, 16: width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  IN_W  operand A.
- in_b  in  IN_W  operand B.
- in_mode  in  2  operation for this beat: 0 CONCAT, 1 SWAP, 2 SUM, 3 XOR.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_q  out  OUT_W  head result.
- out_ovf  out  1  head overflow flag.
- beat_count  out  CNT_W  number of accepted input beats, saturating.

Behaviour:
- Let H = OUT_W/2.
- Result function, evaluated on the accepted beat; in_mode is sampled with the beat:
  - CONCAT: q = {a[IN_W-1 -: H], b[H-1:0]}, ovf = 0.
  - SWAP: q = {b[IN_W-1 -: H], a[H-1:0]}, ovf = 0.
  - SUM: s = zero-extend(a) + zero-extend(b) at OUT_W+1 bits; q = s[OUT_W-1:0], ovf = s[OUT_W].
  - XOR: q = zero-extend(a ^ b) to OUT_W, ovf = 0.
- Input handshake:
  - A beat is accepted on a rising clk edge when in_valid && in_ready.
  - in_ready = (occupancy < DEPTH). It is registered-state-only, with no combinational path from out_ready.
- Output handshake:
  - The head pops on a rising edge when out_valid && out_ready.
  - out_valid = (occupancy != 0).
  - out_q and out_ovf are the head entry. They are held stable while out_valid && !out_ready.
- Latency: a beat accepted at edge N is visible on out_q/out_valid after edge N, i.e. 1 cycle, when the FIFO was empty. Otherwise it appears in FIFO order.
- FIFO: circular buffer with read/write pointers wrapping at DEPTH, plus an occupancy counter 0..DEPTH.
- Simultaneous push and pop (only possible when occupancy < DEPTH):
  - occupancy is unchanged.
  - Data order is preserved.
  - With occupancy 1, the new entry becomes head on the next cycle.
- Full: in_ready = 0. in_a, in_b and in_mode are ignored. No data is dropped or overwritten.
- Empty: out_valid = 0. out_ready is ignored. out_q and out_ovf hold their last value; they are 0 after reset.
- beat_count:
  - Increments by 1 on each accepted input beat.
  - Saturates at 2^CNT_W-1; it does not wrap.
- Reset, when rst is high at a rising edge:
  - occupancy = 0, pointers = 0, out_valid = 0, in_ready = 0 during the reset cycle; in_ready = 1 on the first cycle after rst deasserts.
  - out_q = 0, out_ovf = 0, beat_count = 0.
  - Reset mid-operation discards all queued entries. No pop is reported for them.
- rst has priority over any simultaneous push or pop at the same edge.

Test Plan:
- CONCAT, defaults:
  - Stimulus: a=4'b1011, b=4'b0110, mode 0, out_ready=1.
  - Required: next cycle out_valid=1, out_q=6'b101110 (46), out_ovf=0, beat_count=1.
- SWAP and XOR:
  - Stimulus: the same a/b in SWAP, then in XOR.
  - Required: SWAP gives out_q=6'b011011 (27). XOR gives out_q=6'b001101 (13).
- SUM overflow with IN_W=4, OUT_W=4:
  - Stimulus: a=4'hF, b=4'h2, mode 2.
  - Required: out_q=4'h1, out_ovf=1.
  - The same sum at OUT_W=6 gives out_q=17, out_ovf=0.
- Backpressure, DEPTH=2:
  - Stimulus: out_ready=0, in_valid=1, beats 0..3 in SUM mode with a=b=k.
  - Required: in_ready drops after 2 accepts, and beat_count=2.
  - On raising out_ready, the outputs are 0 then 2, in order.
  - out_q is stable while stalled.
- Simultaneous push and pop at occupancy 1:
  - Required: occupancy stays 1, and a continuous stream delivers one result per cycle with no bubbles.
- Reset mid-stream:
  - Stimulus: assert rst with 2 entries queued.
  - Required: next cycle out_valid=0, beat_count=0, out_q=0. in_ready=1 once rst deasserts.
  - Old entries never reappear.
